// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop add two WIDTH-bit operands LSB first.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' port that turns the operation into a - b.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_inc;
  logic             bit_s, bit_c, last_bit;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is a + ~b + 1, so cin is replaced by a forced carry of 1.
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  assign bit_s    = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign bit_c    = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
  assign cnt_inc  = cnt_q + CW'(1);
  assign last_bit = (cnt_inc == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (last_bit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = done_q;
    sum  = sum_q;
    cout = cout_q;
  end

  // The result register fills from the MSB, so after WIDTH shifts bit 0 holds the LSB.
  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b_load;
          carry_d = carry_load;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = bit_c;
        res_d    = res_q >> 1;
        res_d[WIDTH-1] = bit_s;
        cnt_d    = cnt_inc;
        if (last_bit) begin
          sum_d  = res_d;
          cout_d = bit_c;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: an 8-bit instance checked through an expected-result
// queue and a negedge monitor, plus a 1-bit instance checked directly.
module tb_serial_adder;

  typedef struct packed {
    logic [7:0] s;
    logic       c;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       cin1 = 1'b0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

`ifdef SERIAL_ADDER_SUB_EN
  logic       subIn = 1'b0;
`endif

  exp_t       expQ[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         busyCnt = 0;
  logic [7:0] lastSum = '0;
  logic       lastCout = 1'b0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(subIn),
`endif
    .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(1'b0),
`endif
    .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives one request at a negedge; returns 1 ns after the accepting edge with start low.
  task automatic applyStimulus(input logic [7:0] opA, input logic [7:0] opB, input logic c,
                               input logic [7:0] expS, input logic expC, input bit pushExp);
    exp_t e;
    @(negedge clk);
    a = opA;
    b = opB;
    cin = c;
    start = 1'b1;
    if (pushExp) begin
      e.s = expS;
      e.c = expC;
      expQ.push_back(e);
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitDrain(input int maxCycles);
    int n = 0;
    while (expQ.size() != 0 && n < maxCycles) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    checkOutput("drain_timeout", expQ.size(), 0);
  endtask

  // Monitor: pops one expectation per done pulse and checks outputs hold steady otherwise.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (busy) busyCnt++;
        if (done) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_done", 32'(done), 32'(0));
          end else begin
            e = expQ.pop_front();
            checkOutput("sum", 32'(sum), 32'(e.s));
            checkOutput("cout", 32'(cout), 32'(e.c));
            checkOutput("busy_cycles", busyCnt, 8);
            lastSum = e.s;
            lastCout = e.c;
          end
          busyCnt = 0;
        end else begin
          checkOutput("hold_sum", 32'(sum), 32'(lastSum));
          checkOutput("hold_cout", 32'(cout), 32'(lastCout));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    #12;
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_sum", 32'(sum), 0);
    checkOutput("reset_cout", 32'(cout), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic add, wrap-around and full carry chain
    applyStimulus(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b1);
    waitDrain(20);
    applyStimulus(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1);
    waitDrain(20);
    applyStimulus(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1);
    waitDrain(20);

    // Start while busy must be ignored, and inputs changing after acceptance have no effect
    applyStimulus(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    a = 8'h80;
    b = 8'h80;
    cin = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waitDrain(20);
    repeat (10) @(posedge clk);

    // Start held high: a new operation every 9 clocks
    begin
      logic [7:0] pa[4] = '{8'h11, 8'hF0, 8'hAA, 8'h7F};
      logic [7:0] pb[4] = '{8'h22, 8'h20, 8'h55, 8'h01};
      logic       pc[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic [7:0] ps[4] = '{8'h33, 8'h11, 8'h00, 8'h80};
      logic       pco[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      exp_t e;
      @(negedge clk);
      a = pa[0]; b = pb[0]; cin = pc[0];
      start = 1'b1;
      e.s = ps[0]; e.c = pco[0];
      expQ.push_back(e);
      for (int i = 0; i < 4; i++) begin
        @(posedge clk);
        #1;
        if (i < 3) begin
          a = pa[i+1]; b = pb[i+1]; cin = pc[i+1];
          e.s = ps[i+1]; e.c = pco[i+1];
          expQ.push_back(e);
          repeat (8) @(posedge clk);
        end else begin
          start = 1'b0;
        end
      end
      waitDrain(20);
    end

    // Reset in the middle of a run aborts it
    applyStimulus(8'h12, 8'h34, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    lastSum = '0;
    lastCout = 1'b0;
    busyCnt = 0;
    #1;
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_done", 32'(done), 0);
    checkOutput("abort_sum", 32'(sum), 0);
    checkOutput("abort_cout", 32'(cout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    applyStimulus(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b1);
    waitDrain(20);

`ifdef SERIAL_ADDER_SUB_EN
    subIn = 1'b1;
    applyStimulus(8'h10, 8'h01, 1'b0, 8'h0F, 1'b1, 1'b1);
    waitDrain(20);
    applyStimulus(8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b1);
    waitDrain(20);
    subIn = 1'b0;
    applyStimulus(8'h10, 8'h01, 1'b1, 8'h12, 1'b0, 1'b1);
    waitDrain(20);
`endif

    // Single-bit instance: done one clock after acceptance
    @(negedge clk);
    a1 = 1'b1;
    b1 = 1'b1;
    cin1 = 1'b0;
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    checkOutput("w1_busy_run", 32'(busy1), 1);
    checkOutput("w1_done_early", 32'(done1), 0);
    @(posedge clk);
    #1;
    checkOutput("w1_done", 32'(done1), 1);
    checkOutput("w1_busy_done", 32'(busy1), 0);
    checkOutput("w1_sum", 32'(sum1), 0);
    checkOutput("w1_cout", 32'(cout1), 1);
    @(posedge clk);
    #1;
    checkOutput("w1_done_pulse", 32'(done1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
